// File: rtl/traffic_receiver_mc.sv
// Multi-channel PIFO drain: per-channel LFSR-gated eligibility, round-robin grant,
// optional fixed-length bursts, saturating packet counters and priority-order checking.
module traffic_receiver_mc #(
  parameter int NUM_CH  = 4,
  parameter int RATE_W  = 8,
  parameter int PRIO_W  = 16,
  parameter int CNT_W   = 32,
  parameter int BURST_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*RATE_W-1:0] i__ejrate,
  input  logic [NUM_CH*RATE_W-1:0] i__seed,
  input  logic                     i__mode,
  input  logic [BURST_W-1:0]       i__burst_len,
  input  logic                     i__receive_phase,
  input  logic [NUM_CH-1:0]        i__pifo_ready,
  input  logic [NUM_CH*PRIO_W-1:0] i__packet_priority,
  output logic [NUM_CH-1:0]        o__dequeue,
  output logic [NUM_CH*CNT_W-1:0]  o__pkts_recvd,
  output logic [CNT_W-1:0]         o__total_recvd,
  output logic [NUM_CH-1:0]        o__order_error
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // Feedback tap masks for maximal-length Fibonacci LFSRs (bit n-1 set for tap n).
  function automatic logic [31:0] lfsr_taps(input int w);
    case (w)
      2:       return 32'h0000_0003;
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_D008;
      17:      return 32'h0001_2000;
      18:      return 32'h0002_0400;
      19:      return 32'h0004_0023;
      20:      return 32'h0009_0000;
      21:      return 32'h0014_0000;
      22:      return 32'h0030_0000;
      23:      return 32'h0042_0000;
      24:      return 32'h00E1_0000;
      32:      return 32'h8020_0003;
      default: return 32'h0000_0003 << (w - 2);
    endcase
  endfunction

  localparam logic [RATE_W-1:0] TAPS    = RATE_W'(lfsr_taps(RATE_W));
  localparam logic [RATE_W-1:0] LFSR_ONE = RATE_W'(1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t               state, state_nxt;
  logic [PTR_W-1:0]     ptr, ptr_nxt;
  logic [PTR_W-1:0]     lat_ch, lat_nxt;
  logic [BURST_W-1:0]   remaining, rem_nxt;
  logic [CNT_W-1:0]     total;
  logic                 phase_q;
  logic                 phase_rise;
  logic [NUM_CH-1:0]    elig;
  logic [NUM_CH-1:0]    deq;
  logic                 grant_valid;
  logic [PTR_W-1:0]     gidx;
  logic [PTR_W-1:0]     idx;

  assign phase_rise = i__receive_phase & ~phase_q;

  // Round-robin search starting at ptr.
  always_comb begin
    grant_valid = 1'b0;
    gidx        = '0;
    idx         = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = PTR_W'((int'(ptr) + k) % NUM_CH);
      if (!grant_valid && elig[idx]) begin
        grant_valid = 1'b1;
        gidx        = idx;
      end
    end
  end

  // Burst dequeues bypass LFSR and arbitration; a missed cycle aborts the burst.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    lat_nxt   = lat_ch;
    rem_nxt   = remaining;
    deq       = '0;
    if (!reset) begin
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            deq[gidx] = 1'b1;
            ptr_nxt   = PTR_W'((int'(gidx) + 1) % NUM_CH);
            if (i__mode && (i__burst_len > BURST_W'(1))) begin
              state_nxt = ST_BURST;
              lat_nxt   = gidx;
              rem_nxt   = i__burst_len - BURST_W'(1);
            end
          end
        end
        ST_BURST: begin
          if (i__receive_phase && i__pifo_ready[lat_ch]) begin
            deq[lat_ch] = 1'b1;
            rem_nxt     = remaining - BURST_W'(1);
            if (remaining == BURST_W'(1)) begin
              state_nxt = ST_IDLE;
            end
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      lat_ch    <= '0;
      remaining <= '0;
      total     <= '0;
      phase_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      lat_ch    <= lat_nxt;
      remaining <= rem_nxt;
      phase_q   <= i__receive_phase;
      if ((|deq) && (total != {CNT_W{1'b1}})) begin
        total <= total + CNT_W'(1);
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [RATE_W-1:0] seed_c;
    logic [RATE_W-1:0] rate_c;
    logic [PRIO_W-1:0] prio_c;
    logic [RATE_W-1:0] lfsr;
    logic [CNT_W-1:0]  cnt;
    logic [PRIO_W-1:0] last_prio;
    logic              armed;
    logic              order_err;
    logic              armed_eff;

    assign seed_c    = i__seed[c*RATE_W +: RATE_W];
    assign rate_c    = i__ejrate[c*RATE_W +: RATE_W];
    assign prio_c    = i__packet_priority[c*PRIO_W +: PRIO_W];
    // A phase start disarms in the same cycle, so its first dequeue is never compared.
    assign armed_eff = armed & ~phase_rise;
    assign elig[c]   = i__receive_phase & i__pifo_ready[c] & (lfsr < rate_c);

    always_ff @(posedge clk) begin
      if (reset) begin
        lfsr      <= (seed_c == '0) ? LFSR_ONE : seed_c;
        cnt       <= '0;
        last_prio <= '0;
        armed     <= 1'b0;
        order_err <= 1'b0;
      end else if (deq[c]) begin
        lfsr      <= {lfsr[RATE_W-2:0], ^(lfsr & TAPS)};
        if (cnt != {CNT_W{1'b1}}) begin
          cnt <= cnt + CNT_W'(1);
        end
        if (armed_eff && (prio_c < last_prio)) begin
          order_err <= 1'b1;
        end
        last_prio <= prio_c;
        armed     <= 1'b1;
      end else if (phase_rise) begin
        armed <= 1'b0;
      end
    end

    assign o__pkts_recvd[c*CNT_W +: CNT_W] = cnt;
    assign o__order_error[c]               = order_err;
  end

  assign o__dequeue     = deq;
  assign o__total_recvd = total;

endmodule

// File: tb/tb_traffic_receiver_mc.sv
// Directed bench for traffic_receiver_mc: arbitration order, bursts, LFSR gating,
// ordering flags and counter saturation (second instance with 4-bit counters).
module tb_traffic_receiver_mc;

  localparam int NUM_CH  = 4;
  localparam int RATE_W  = 8;
  localparam int PRIO_W  = 16;
  localparam int CNT_W   = 32;
  localparam int BURST_W = 4;
  localparam int SAT_W   = 4;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_CH*RATE_W-1:0] ejrate;
  logic [NUM_CH*RATE_W-1:0] seed;
  logic                     mode;
  logic [BURST_W-1:0]       burst_len;
  logic                     phase;
  logic [NUM_CH-1:0]        ready;
  logic [NUM_CH*PRIO_W-1:0] prio;

  logic [NUM_CH-1:0]        deq;
  logic [NUM_CH*CNT_W-1:0]  pkts;
  logic [CNT_W-1:0]         total;
  logic [NUM_CH-1:0]        oerr;

  logic [NUM_CH-1:0]        sat_deq;
  logic [NUM_CH*SAT_W-1:0]  sat_pkts;
  logic [SAT_W-1:0]         sat_total;
  logic [NUM_CH-1:0]        sat_oerr;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  traffic_receiver_mc #(
    .NUM_CH(NUM_CH), .RATE_W(RATE_W), .PRIO_W(PRIO_W), .CNT_W(CNT_W), .BURST_W(BURST_W)
  ) dut (
    .clk(clk), .reset(reset), .i__ejrate(ejrate), .i__seed(seed), .i__mode(mode),
    .i__burst_len(burst_len), .i__receive_phase(phase), .i__pifo_ready(ready),
    .i__packet_priority(prio), .o__dequeue(deq), .o__pkts_recvd(pkts),
    .o__total_recvd(total), .o__order_error(oerr)
  );

  traffic_receiver_mc #(
    .NUM_CH(NUM_CH), .RATE_W(RATE_W), .PRIO_W(PRIO_W), .CNT_W(SAT_W), .BURST_W(BURST_W)
  ) dut_sat (
    .clk(clk), .reset(reset), .i__ejrate(ejrate), .i__seed(seed), .i__mode(mode),
    .i__burst_len(burst_len), .i__receive_phase(phase), .i__pifo_ready(ready),
    .i__packet_priority(prio), .o__dequeue(sat_deq), .o__pkts_recvd(sat_pkts),
    .o__total_recvd(sat_total), .o__order_error(sat_oerr)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_defaults;
    ejrate    = 32'hFFFF_FFFF;
    seed      = 32'h0403_0201;
    mode      = 1'b0;
    burst_len = 4'd0;
    phase     = 1'b0;
    ready     = 4'h0;
    prio      = '0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    phase = 1'b0;
    ready = 4'h0;
    tick;
    tick;
    reset = 1'b0;
  endtask

  // Applies a sequence of cycles and checks the combinational strobe before each edge.
  task automatic run_seq(input string name, input int n, input logic [3:0] exp_seq [8]);
    for (int i = 0; i < n; i++) begin
      #1;
      n_vec++;
      if (deq !== exp_seq[i]) begin
        n_err++;
        $display("FAIL %s cycle %0d: dequeue=%b expected=%b", name, i, deq, exp_seq[i]);
      end
      tick;
    end
  endtask

  task automatic test_reset;
    set_defaults;
    phase = 1'b1;
    ready = 4'hF;
    reset = 1'b1;
    #1;
    n_vec++;
    if (deq !== 4'h0) begin
      n_err++;
      $display("FAIL reset_dequeue: dequeue=%b expected=0000", deq);
    end
    tick;
    n_vec++;
    if (pkts !== '0 || total !== '0 || oerr !== 4'h0) begin
      n_err++;
      $display("FAIL reset_state: pkts=%h total=%0d oerr=%b expected all zero", pkts, total, oerr);
    end
    n_vec++;
    if (sat_pkts !== '0 || sat_total !== '0) begin
      n_err++;
      $display("FAIL reset_sat_state: pkts=%h total=%0d expected zero", sat_pkts, sat_total);
    end
    reset = 1'b0;
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_seq [8];
    exp_seq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
    set_defaults;
    do_reset;
    phase = 1'b1;
    ready = 4'hF;
    run_seq("round_robin", 8, exp_seq);
    for (int c = 0; c < NUM_CH; c++) begin
      n_vec++;
      if (pkts[c*CNT_W +: CNT_W] !== 32'd2) begin
        n_err++;
        $display("FAIL rr_count ch%0d: got=%0d expected=2", c, pkts[c*CNT_W +: CNT_W]);
      end
    end
    n_vec++;
    if (total !== 32'd8) begin
      n_err++;
      $display("FAIL rr_total: got=%0d expected=8", total);
    end
  endtask

  task automatic test_ejrate_zero;
    logic [3:0] exp_seq [8];
    logic [31:0] exp_cnt [4];
    exp_seq = '{4'h1, 4'h4, 4'h8, 4'h1, 4'h4, 4'h8, 4'h0, 4'h0};
    exp_cnt = '{32'd2, 32'd0, 32'd2, 32'd2};
    set_defaults;
    ejrate = 32'hFFFF_00FF;
    do_reset;
    phase = 1'b1;
    ready = 4'hF;
    run_seq("ejrate_zero", 6, exp_seq);
    for (int c = 0; c < NUM_CH; c++) begin
      n_vec++;
      if (pkts[c*CNT_W +: CNT_W] !== exp_cnt[c]) begin
        n_err++;
        $display("FAIL ejz_count ch%0d: got=%0d expected=%0d", c, pkts[c*CNT_W +: CNT_W], exp_cnt[c]);
      end
    end
  endtask

  task automatic test_burst;
    logic [3:0] exp_seq [8];
    exp_seq = '{4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0};
    set_defaults;
    mode      = 1'b1;
    burst_len = 4'd3;
    do_reset;
    phase = 1'b1;
    ready = 4'hF;
    run_seq("burst3", 6, exp_seq);
    n_vec++;
    if (total !== 32'd6) begin
      n_err++;
      $display("FAIL burst3_total: got=%0d expected=6", total);
    end
  endtask

  task automatic test_burst_abort;
    logic [3:0] exp_seq [8];
    set_defaults;
    mode      = 1'b1;
    burst_len = 4'd4;
    do_reset;
    phase = 1'b1;
    ready = 4'hF;
    exp_seq = '{4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    run_seq("burst_abort_a", 2, exp_seq);
    ready = 4'hE;
    run_seq("burst_abort_b", 1, '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0});
    ready = 4'hF;
    run_seq("burst_abort_c", 1, '{4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0});
    n_vec++;
    if (pkts[0 +: CNT_W] !== 32'd2 || pkts[CNT_W +: CNT_W] !== 32'd1) begin
      n_err++;
      $display("FAIL burst_abort_counts: ch0=%0d ch1=%0d expected 2 and 1",
               pkts[0 +: CNT_W], pkts[CNT_W +: CNT_W]);
    end
  endtask

  task automatic test_burst_len_zero;
    logic [3:0] exp_seq [8];
    exp_seq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h0, 4'h0, 4'h0};
    set_defaults;
    mode      = 1'b1;
    burst_len = 4'd0;
    do_reset;
    phase = 1'b1;
    ready = 4'hF;
    run_seq("burst_len0", 5, exp_seq);
  endtask

  task automatic test_mode_change;
    logic [3:0] exp_seq [8];
    set_defaults;
    mode      = 1'b1;
    burst_len = 4'd3;
    do_reset;
    phase = 1'b1;
    ready = 4'hF;
    run_seq("mode_chg_a", 1, '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0});
    mode = 1'b0;
    exp_seq = '{4'h1, 4'h1, 4'h2, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0};
    run_seq("mode_chg_b", 4, exp_seq);
  endtask

  task automatic test_lfsr_gate;
    logic [3:0] exp_seq [8];
    exp_seq = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    set_defaults;
    seed   = 32'h0403_FF00;
    ejrate = 32'h0000_FF02;
    do_reset;
    phase = 1'b1;
    ready = 4'hF;
    run_seq("lfsr_gate", 5, exp_seq);
  endtask

  task automatic test_reset_mid_burst;
    set_defaults;
    mode      = 1'b1;
    burst_len = 4'd4;
    do_reset;
    phase = 1'b1;
    ready = 4'hF;
    tick;
    tick;
    reset = 1'b1;
    #1;
    n_vec++;
    if (deq !== 4'h0) begin
      n_err++;
      $display("FAIL reset_mid_burst_deq: dequeue=%b expected=0000", deq);
    end
    tick;
    reset = 1'b0;
    #1;
    n_vec++;
    if (deq !== 4'h1 || pkts[0 +: CNT_W] !== 32'd0) begin
      n_err++;
      $display("FAIL reset_mid_burst_after: dequeue=%b ch0=%0d expected 0001 and 0",
               deq, pkts[0 +: CNT_W]);
    end
    tick;
  endtask

  task automatic test_ordering;
    set_defaults;
    do_reset;
    phase = 1'b1;
    ready = 4'h4;
    prio[2*PRIO_W +: PRIO_W] = 16'd5;
    tick;
    prio[2*PRIO_W +: PRIO_W] = 16'd7;
    tick;
    n_vec++;
    if (oerr !== 4'h0) begin
      n_err++;
      $display("FAIL order_rising: oerr=%b expected=0000", oerr);
    end
    prio[2*PRIO_W +: PRIO_W] = 16'd3;
    tick;
    n_vec++;
    if (oerr !== 4'h4) begin
      n_err++;
      $display("FAIL order_inversion: oerr=%b expected=0100", oerr);
    end
    ready = 4'h2;
    prio[1*PRIO_W +: PRIO_W] = 16'd9;
    tick;
    phase = 1'b0;
    ready = 4'h0;
    tick;
    phase = 1'b1;
    ready = 4'h2;
    prio[1*PRIO_W +: PRIO_W] = 16'd1;
    tick;
    n_vec++;
    if (oerr !== 4'h4) begin
      n_err++;
      $display("FAIL order_new_phase: oerr=%b expected=0100", oerr);
    end
    tick;
    n_vec++;
    if (oerr !== 4'h4 || pkts[CNT_W +: CNT_W] !== 32'd3) begin
      n_err++;
      $display("FAIL order_equal_prio: oerr=%b ch1=%0d expected 0100 and 3",
               oerr, pkts[CNT_W +: CNT_W]);
    end
  endtask

  task automatic test_saturation;
    int seen;
    seen = 0;
    set_defaults;
    do_reset;
    phase = 1'b1;
    ready = 4'h1;
    for (int i = 0; i < 80 && seen < 20; i++) begin
      #1;
      if (sat_deq[0]) seen++;
      tick;
    end
    ready = 4'h0;
    n_vec++;
    if (seen != 20) begin
      n_err++;
      $display("FAIL sat_timeout: dequeues seen=%0d required=20", seen);
    end
    n_vec++;
    if (sat_pkts[0 +: SAT_W] !== 4'd15 || sat_total !== 4'd15) begin
      n_err++;
      $display("FAIL sat_counts: ch0=%0d total=%0d expected 15 and 15", sat_pkts[0 +: SAT_W], sat_total);
    end
    n_vec++;
    if (pkts[0 +: CNT_W] !== 32'd20 || total !== 32'd20) begin
      n_err++;
      $display("FAIL wide_counts: ch0=%0d total=%0d expected 20 and 20", pkts[0 +: CNT_W], total);
    end
  endtask

  initial begin
    set_defaults;
    reset = 1'b1;
    test_reset;
    test_round_robin;
    test_ejrate_zero;
    test_burst;
    test_burst_abort;
    test_burst_len_zero;
    test_mode_change;
    test_lfsr_gate;
    test_reset_mid_burst;
    test_ordering;
    test_saturation;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
